z480_fetch_unit: RTL and testbench
==================================

Name: z480_fetch_unit

Overview:
Instruction fetch front-end for z480_core. Sits between the fabric memory port and the core's decode stage. It issues 32-bit aligned read requests ahead of decode, buffers returned words with their PC in a small queue, and presents them to decode with a valid/ready handshake. Branch/jump redirects flush the queue and discard responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding fabric reads (1..DEPTH)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
req_valid  out  1  fabric read request valid
req_ready  in  1  fabric accepts request
req_addr  out  32  word-aligned byte address (bits[1:0]=0)
rsp_valid  in  1  fabric read response valid (in request order)
rsp_data  in  32  little-endian instruction word
rsp_err  in  1  bus error on this response
redirect_valid  in  1  decode/execute requests new PC
redirect_pc  in  32  target PC; bits[1:0] ignored
fetch_halt  in  1  debug halt: suppress new requests
if_valid  out  1  instruction available to decode
if_ready  in  1  decode consumes this cycle
if_pc  out  32  PC of presented instruction
if_instr  out  32  instruction word
if_fault  out  1  presented entry is a fetch bus error
outstanding  out  2  in-flight request count (debug/trace)

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, queue empty, outstanding=0, stale=0, state=RUN. Outputs: req_valid=0, req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_fault=0. rst mid-transfer drops everything. Responses arriving after reset for pre-reset requests are the fabric's responsibility; the fabric is reset together with this block.
- States: RUN (issue allowed), FAULT (error seen, no issue until redirect).
- Issue condition: req_valid=1 when all of the following hold: state=RUN, !fetch_halt, outstanding<MAX_OUT, and (queue_count+outstanding-stale)<DEPTH. This is credit-based, so no response can ever overflow the queue.
- Handshake: once req_valid is asserted, req_valid and req_addr hold until req_ready. Neither redirect nor fetch_halt withdraws a held request.
- On accept (req_valid&&req_ready): outstanding++, fetch_pc+=4, wrapping mod 2^32.
- Response: outstanding--. If stale>0, the response is dropped and stale--. Otherwise {pc,data,err} is enqueued the same cycle and the response PC advances by 4. If err=1, the entry has fault=1 and the state goes to FAULT.
- Simultaneous accept and response: outstanding is unchanged.
- Presentation: if_* reflect the queue head combinationally from registered storage. A pop occurs on if_valid&&if_ready.
- Fill-to-use latency: a response at cycle N gives if_valid=1 at cycle N+1. There is no bypass.
- Redirect (highest priority):
  - Queue is flushed the same cycle; a simultaneous pop is ignored.
  - stale = outstanding after this cycle's accept/response updates. A held-but-unaccepted request becomes stale once it is accepted.
  - fetch_pc = {redirect_pc[31:2],2'b00}; state=RUN.
  - If a response arrives in the redirect cycle, it is dropped.
  - The first new request is issued no earlier than the cycle after the redirect.
- FAULT: the fault entry is still delivered to decode. No further entries are enqueued; any later non-stale responses are dropped.
- fetch_halt: blocks new issue only. In-flight responses are still enqueued and the queue still drains.
- Full queue with if_ready=0: no issue (credit rule); the queue holds.

Decomposition:
- z480_pkg adds:
  - z480_fetch_entry_t {pc[31:0], instr[31:0], fault}
  - Z480_INSTR_BYTES=4
  - z480_fetch_state_e {FETCH_RUN, FETCH_FAULT}
- One sub-module, z480_fetch_fifo: parameterised sync FIFO of z480_fetch_entry_t with push, pop, flush, count, empty and full.

Test Plan:
- Straight-line code, zero-wait memory with 0x2001_0040 at 0x0, 0x2002_1234 at 0x4 → decode sees pc 0x0 then 0x4 with matching words; first if_valid 2 cycles after the first accept.
- Backpressure: hold if_ready=0 with DEPTH=4 → exactly 4 accepts, then req_valid=0; release → pc 0x0,0x4,0x8,0xC in order, with no loss or duplication.
- Redirect with 2 outstanding to redirect_pc=0x2E → both old responses dropped; next req_addr=0x2C; first if_pc=0x2C.
- Bus error on the response for 0x8 → if_fault=1 with if_pc=0x8; no further requests; redirect to 0x0 resumes fetching.
- Fabric stall: req_ready=0 for 5 cycles while redirect pulses → req_addr stays stable until accept; that request is dropped as stale; the redirect target is fetched next.
- rst asserted mid-stream with if_valid=1 → the next cycle has if_valid=0 and outstanding=0; the next request is at RESET_PC.

Source files
------------

// File: rtl/z480_pkg.sv
// Shared types and constants for the z480 instruction fetch front-end.
package z480_pkg;

  localparam int Z480_INSTR_BYTES = 4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } z480_fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } z480_fetch_entry_t;

endpackage

// File: rtl/z480_fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it in one cycle.
module z480_fetch_fifo
  import z480_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  z480_fetch_entry_t push_entry,
  input  logic              pop,
  input  logic              flush,
  output z480_fetch_entry_t head,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  z480_fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/z480_fetch_unit.sv
// z480 instruction fetch: credit-limited read issue, in-order response queue,
// redirect flush with stale-response discard, and a sticky bus-fault state.
module z480_fetch_unit
  import z480_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic [1:0]  outstanding
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] MAX_W   = MAX_OUT[CW-1:0];

  z480_fetch_state_e state;
  logic [31:0]       fetch_pc;
  logic [31:0]       rsp_pc;
  logic [31:0]       hold_addr;
  logic [31:0]       target_pc;
  logic              hold;
  logic              hold_stale;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     stale;
  logic [CW-1:0]     q_count;
  logic [CW:0]       credit;
  logic              issue_ok;
  logic              accept;
  logic              rsp_keep;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic              unused;
  z480_fetch_entry_t head;
  z480_fetch_entry_t push_entry;

  // Queue slots already promised: buffered entries plus live (non-stale) reads.
  assign credit   = {1'b0, q_count} + {1'b0, out_cnt} - {1'b0, stale};
  assign issue_ok = (state == FETCH_RUN) && !fetch_halt && (out_cnt < MAX_W)
                    && (credit < DEPTH_W) && !q_full;
  assign req_valid = !rst && (hold || issue_ok);
  assign req_addr  = hold ? hold_addr : fetch_pc;
  assign accept    = req_valid && req_ready;
  assign out_next  = out_cnt + CW'(accept) - CW'(rsp_valid);
  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign unused    = ^redirect_pc[1:0];

  assign rsp_keep   = rsp_valid && !redirect_valid && (stale == '0) && (state == FETCH_RUN);
  assign push_entry = '{pc: rsp_pc, instr: rsp_data, fault: rsp_err};
  assign pop        = !q_empty && if_ready && !redirect_valid;

  assign if_valid    = !q_empty;
  assign if_pc       = q_empty ? 32'h0 : head.pc;
  assign if_instr    = q_empty ? 32'h0 : head.instr;
  assign if_fault    = !q_empty && head.fault;
  assign outstanding = out_cnt[1:0];

  z480_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_RUN;
      fetch_pc   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      hold_addr  <= RESET_PC;
      hold       <= 1'b0;
      hold_stale <= 1'b0;
      out_cnt    <= '0;
      stale      <= '0;
    end else begin
      out_cnt <= out_next;
      // A request once offered stays on the bus; a redirect only marks it stale.
      if (accept) begin
        hold       <= 1'b0;
        hold_stale <= 1'b0;
      end else if (req_valid) begin
        hold       <= 1'b1;
        hold_addr  <= req_addr;
        hold_stale <= hold_stale || redirect_valid;
      end
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        stale    <= out_next;
        state    <= FETCH_RUN;
      end else begin
        if (accept && !hold_stale) begin
          fetch_pc <= fetch_pc + 32'(Z480_INSTR_BYTES);
        end
        stale <= stale - CW'(rsp_valid && (stale != '0)) + CW'(accept && hold_stale);
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'(Z480_INSTR_BYTES);
          if (rsp_err) begin
            state <= FETCH_FAULT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_z480_fetch_unit.sv
// Bench for z480_fetch_unit: zero-wait fabric model, delivery scoreboard,
// redirect vector table and hand-written stall/fault/reset sequences.
module tb_z480_fetch_unit;
  import z480_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic [1:0]  outstanding;

  always #5 clk = ~clk;

  z480_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_halt     (fetch_halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault),
    .outstanding    (outstanding)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [64:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] acc_hist[$];
  bit          stall    = 1'b0;
  bit          rsp_en   = 1'b1;
  bit          err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc;
    int          n;
  } redir_vec_t;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0040;
      32'h0000_0004: return 32'h2002_1234;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] hist_at(int i);
    if (acc_hist.size() > i) return acc_hist[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(string name, logic [64:0] act, logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- clock/reset and driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    fetch_halt     = 1'b0;
    stall          = 1'b0;
    rsp_en         = 1'b1;
    err_en         = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    acc_hist.delete();
  endtask

  task automatic expect_run(logic [31:0] pc, int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc + 32'(4 * i);
      exp_q.push_back({p, mem_word(p), 1'b0});
    end
  endtask

  task automatic drain(string name, int max_cyc);
    int k;
    k = 0;
    if_ready = 1'b1;
    while (exp_q.size() > 0 && k < max_cyc) begin
      cyc(1);
      k++;
    end
    if_ready = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: timeout with %0d entries still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect_to(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    acc_hist.delete();
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  // ---------------- fabric model: responds the cycle after accept ----------------
  initial begin
    logic [31:0] a;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend_q.delete();
      else if (req_valid && req_ready) begin
        pend_q.push_back(req_addr);
        acc_hist.push_back(req_addr);
      end
      @(posedge clk);
      #2;
      req_ready = !stall;
      if (!rst && rsp_en && pend_q.size() > 0) begin
        a = pend_q.pop_front();
        rsp_valid = 1'b1;
        rsp_data  = mem_word(a);
        rsp_err   = err_en && (a == err_addr);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        rsp_err   = 1'b0;
      end
    end
  end

  // ---------------- scoreboard: compare every delivered entry ----------------
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_entry: got pc=0x%0h instr=0x%0h fault=%0b, none expected",
                 if_pc, if_instr, if_fault);
      end else begin
        check("if_entry", {if_pc, if_instr, if_fault}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    redir_vec_t vecs[4];
    int first_acc;
    int first_v;
    int k;

    vecs[0] = '{32'h0000_002E, 32'h0000_002C, 3};
    vecs[1] = '{32'h0000_0101, 32'h0000_0100, 2};
    vecs[2] = '{32'hFFFF_FFFA, 32'hFFFF_FFF8, 3};
    vecs[3] = '{32'h0000_0013, 32'h0000_0010, 2};

    rst = 1'b1;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fetch_halt = 1'b0;
    cyc(2);
    @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_fault", if_fault, 0);
    check("rst_outstanding", outstanding, 0);

    // Straight-line fetch and fill-to-use latency.
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_ready = 1'b1;
    expect_run(32'h0, 2);
    first_acc = -1;
    first_v = -1;
    k = 0;
    while (exp_q.size() > 0 && k < 30) begin
      @(negedge clk);
      if (first_acc < 0 && req_valid && req_ready) first_acc = k;
      if (first_v < 0 && if_valid) first_v = k;
      cyc(1);
      k++;
    end
    if_ready = 1'b0;
    check("straight_drain", exp_q.size(), 0);
    check("fill_latency", first_v - first_acc, 2);

    // Backpressure: credit limit stops issue at DEPTH.
    do_reset();
    cyc(12);
    @(negedge clk);
    check("bp_accepts", acc_hist.size(), 4);
    check("bp_req_valid", req_valid, 0);
    check("bp_if_valid", if_valid, 1);
    check("bp_outstanding", outstanding, 0);
    cyc(1);
    expect_run(32'h0, 4);
    drain("bp_drain", 30);

    // Redirect with two reads in flight, table-driven targets.
    foreach (vecs[v]) begin
      do_reset();
      rsp_en = 1'b0;
      k = 0;
      while (outstanding != 2'd2 && k < 10) begin
        cyc(1);
        k++;
      end
      check("redir_out2", outstanding, 2);
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].target;
      acc_hist.delete();
      @(negedge clk);
      check("redir_no_issue", req_valid, 0);
      cyc(1);
      redirect_valid = 1'b0;
      rsp_en = 1'b1;
      expect_run(vecs[v].exp_pc, vecs[v].n);
      drain("redir_drain", 40);
      check("redir_first_addr", hist_at(0), vecs[v].exp_pc);
    end

    // Bus error on 0x8: fault entry delivered, issue stops until redirect.
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h8;
    expect_run(32'h0, 2);
    exp_q.push_back({32'h8, mem_word(32'h8), 1'b1});
    drain("fault_drain", 30);
    cyc(4);
    acc_hist.delete();
    cyc(8);
    @(negedge clk);
    check("fault_no_accepts", acc_hist.size(), 0);
    check("fault_req_valid", req_valid, 0);
    check("fault_if_valid", if_valid, 0);
    cyc(1);
    err_en = 1'b0;
    redirect_to(32'h0);
    expect_run(32'h0, 2);
    drain("fault_resume", 30);
    check("fault_resume_addr", hist_at(0), 32'h0);

    // Halt blocks issue; fabric stall holds request across redirect and halt.
    do_reset();
    fetch_halt = 1'b1;
    stall = 1'b1;
    cyc(3);
    @(negedge clk);
    check("halt_req_valid", req_valid, 0);
    check("halt_accepts", acc_hist.size(), 0);
    cyc(1);
    fetch_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      redirect_valid = (i == 1);
      redirect_pc    = 32'h40;
      fetch_halt     = (i == 3);
      @(negedge clk);
      check("stall_req_valid", req_valid, 1);
      check("stall_req_addr", req_addr, 32'h0);
    end
    cyc(1);
    redirect_valid = 1'b0;
    fetch_halt = 1'b0;
    stall = 1'b0;
    expect_run(32'h40, 2);
    drain("stall_drain", 30);
    check("stall_first_acc", hist_at(0), 32'h0);
    check("stall_second_acc", hist_at(1), 32'h40);

    // Reset in the middle of a stream.
    do_reset();
    cyc(6);
    @(negedge clk);
    check("mid_if_valid_before", if_valid, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    check("mid_if_valid_after", if_valid, 0);
    check("mid_outstanding", outstanding, 0);
    check("mid_req_valid", req_valid, 0);
    cyc(1);
    rst = 1'b0;
    acc_hist.delete();
    cyc(3);
    check("mid_restart_addr", hist_at(0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
